// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 32;

   // Step-counter width for a given operand width; never narrower than one bit.
   function automatic int div_cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor_abs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor_abs always holds, so the MSB of the (WIDTH+1)-bit
   // difference is a reliable borrow flag.
   always_comb begin
      shifted = {rem, q[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_abs};
      if (diff[WIDTH]) begin
         rem_next = shifted[WIDTH-1:0];
         q_next   = {q[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = diff[WIDTH-1:0];
         q_next   = {q[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle signed divider (MIPS DIV): lo = quotient, hi = remainder.
// Define DIV_DIVU_EN to add the is_unsigned input for DIVU support.
module div_seq_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV_DIVU_EN
   input  logic             is_unsigned,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = div_cnt_width(WIDTH);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             signed_op;
   logic             dividend_neg;
   logic             divisor_neg;

`ifdef DIV_DIVU_EN
   assign signed_op = ~is_unsigned;
`else
   assign signed_op = 1'b1;
`endif

   assign dividend_neg = signed_op & dividend[WIDTH-1];
   assign divisor_neg  = signed_op & divisor[WIDTH-1];

   // quo_q starts as |dividend| and is shifted out MSB-first while the
   // quotient bits are shifted in at the bottom.
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem         (rem_q),
      .q           (quo_q),
      .divisor_abs (dvs_q),
      .rem_next    (step_rem),
      .q_next      (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  done_d = 1'b1;
                  dz_d   = 1'b1;
               end else begin
                  state_d   = RUN;
                  busy_d    = 1'b1;
                  cnt_d     = CNT_W'(WIDTH - 1);
                  rem_d     = '0;
                  quo_d     = dividend_neg ? -dividend : dividend;
                  dvs_d     = divisor_neg  ? -divisor  : divisor;
                  neg_quo_d = dividend_neg ^ divisor_neg;
                  neg_rem_d = dividend_neg;
               end
            end
         end
         RUN: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FIX: begin
            // Truncation toward zero: remainder takes the dividend's sign.
            lo_d    = neg_quo_q ? -quo_q : quo_q;
            hi_d    = neg_rem_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
